// File: rtl/vga_fetch_sched.sv
// rtl/vga_fetch_sched.sv - ping-pong line buffer fetch scheduler for VGA output
module vga_fetch_sched #(
  parameter int HDISP = 800,
  parameter int VDISP = 480,
  parameter int BURST = 16
) (
  input  logic                     pixel_clk,
  input  logic                     pixel_rst,
  input  logic                     frame_start,
  input  logic                     disp_line_end,
  output logic                     req_valid,
  input  logic                     req_ready,
  output logic [$clog2(VDISP)-1:0] req_line,
  output logic [$clog2(HDISP)-1:0] req_x,
  output logic                     req_bank,
  input  logic                     rsp_done,
  output logic                     disp_bank,
  output logic                     disp_ready,
  output logic                     underflow,
  output logic                     frame_fetched
);

  localparam int LW = $clog2(VDISP);
  localparam int XW = $clog2(HDISP);
  localparam logic [XW:0]   BURST_W   = (XW+1)'(BURST);
  localparam logic [XW:0]   HDISP_W   = (XW+1)'(HDISP);
  localparam logic [LW-1:0] LAST_LINE = LW'(VDISP - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]  state;
  logic [1:0]  full;
  logic [1:0]  full_n;
  logic        restart_pend;
  logic [XW:0] x_sum;
  logic        burst_done;
  logic        line_done;
  logic        init_now;
  logic        set_pend;

  assign disp_ready = full[disp_bank];

  // Burst completion decode and frame (re)start decisions.
  always_comb begin
    burst_done = (state == WAIT) && rsp_done;
    x_sum      = {1'b0, req_x} + BURST_W;
    // A pending restart replaces the line update of the burst it waited for.
    line_done  = burst_done && !restart_pend && (x_sum == HDISP_W);
    // Restart immediately when nothing is in flight, or when the outstanding
    // burst finishes in the very cycle frame_start arrives.
    init_now   = (frame_start && ((state == IDLE) || (state == DONE) ||
                                  ((state == ISSUE) && !req_valid))) ||
                 (burst_done && (restart_pend || frame_start));
    // A presented request or an outstanding burst must run to completion.
    set_pend   = frame_start && (((state == ISSUE) && req_valid) ||
                                 ((state == WAIT) && !rsp_done));
  end

  // Next bank occupancy: display release and fetch completion hit different banks.
  always_comb begin
    full_n = full;
    if (disp_line_end) full_n[disp_bank] = 1'b0;
    if (line_done)     full_n[req_bank]  = 1'b1;
  end

  // Fetch sequencing FSM, bank bookkeeping and display-side tracking.
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      state         <= IDLE;
      req_valid     <= 1'b0;
      req_line      <= '0;
      req_x         <= '0;
      req_bank      <= 1'b0;
      disp_bank     <= 1'b0;
      full          <= 2'b00;
      underflow     <= 1'b0;
      frame_fetched <= 1'b0;
      restart_pend  <= 1'b0;
    end else if (init_now) begin
      state         <= ISSUE;
      req_valid     <= 1'b0;
      req_line      <= '0;
      req_x         <= '0;
      req_bank      <= 1'b0;
      disp_bank     <= 1'b0;
      full          <= 2'b00;
      underflow     <= 1'b0;
      frame_fetched <= 1'b0;
      restart_pend  <= 1'b0;
    end else begin
      full <= full_n;
      if (set_pend) restart_pend <= 1'b1;
      if (disp_line_end) begin
        // Toggle even on underflow so the display stays bank-aligned.
        disp_bank <= ~disp_bank;
        if (!full[disp_bank]) underflow <= 1'b1;
      end
      case (state)
        ISSUE: begin
          if (req_valid) begin
            if (req_ready) begin
              req_valid <= 1'b0;
              state     <= WAIT;
            end
          end else begin
            req_valid <= ~full_n[req_bank];
          end
        end
        WAIT: begin
          if (rsp_done) begin
            state <= ISSUE;
            if (line_done) begin
              req_x    <= '0;
              req_bank <= ~req_bank;
              req_line <= req_line + 1'b1;
              if (req_line == LAST_LINE) begin
                state         <= DONE;
                frame_fetched <= 1'b1;
              end
            end else begin
              req_x <= x_sum[XW-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fetch_sched.sv
// tb/tb_vga_fetch_sched.sv - randomized self-checking bench for vga_fetch_sched
module tb_vga_fetch_sched;

  localparam int HDISP = 800;
  localparam int VDISP = 120;
  localparam int BURST = 16;
  localparam int BPL   = HDISP / BURST;
  localparam int LW    = $clog2(VDISP);
  localparam int XW    = $clog2(HDISP);

  logic          pixel_clk = 1'b0;
  logic          pixel_rst = 1'b1;
  logic          frame_start = 1'b0;
  logic          disp_line_end = 1'b0;
  logic          req_ready = 1'b0;
  logic          rsp_done = 1'b0;
  logic          req_valid;
  logic [LW-1:0] req_line;
  logic [XW-1:0] req_x;
  logic          req_bank;
  logic          disp_bank;
  logic          disp_ready;
  logic          underflow;
  logic          frame_fetched;

  int vectors = 0;
  int miscompares = 0;
  // Reference model: bursts completed and lines released since frame init.
  int m_bursts = 0;
  int m_disp = 0;

  vga_fetch_sched #(.HDISP(HDISP), .VDISP(VDISP), .BURST(BURST)) dut (
    .pixel_clk(pixel_clk), .pixel_rst(pixel_rst),
    .frame_start(frame_start), .disp_line_end(disp_line_end),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_line(req_line), .req_x(req_x), .req_bank(req_bank),
    .rsp_done(rsp_done), .disp_bank(disp_bank), .disp_ready(disp_ready),
    .underflow(underflow), .frame_fetched(frame_fetched)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    @(negedge pixel_clk);
    frame_start = 1'b0;
  endtask

  task automatic pulse_disp();
    disp_line_end = 1'b1;
    @(negedge pixel_clk);
    disp_line_end = 1'b0;
    m_disp++;
  endtask

  // Act as the framebuffer reader for one burst, checking it against the model.
  task automatic do_burst(input int rdy_dly, input int rsp_dly, input bit dle);
    int t;
    int f;
    logic [LW-1:0] el;
    logic [XW-1:0] ex;
    logic eb;
    logic exp_rdy;
    logic exp_ff;
    f  = m_bursts / BPL;
    el = LW'(f);
    ex = XW'((m_bursts % BPL) * BURST);
    eb = f[0];
    t = 0;
    while (req_valid !== 1'b1 && t < 64) begin
      @(negedge pixel_clk);
      t++;
    end
    vectors++;
    if (req_valid !== 1'b1) begin
      $display("FAIL req_timeout: req_valid=%b required 1", req_valid);
      miscompares++;
      return;
    end
    vectors++;
    if (req_line !== el || req_x !== ex || req_bank !== eb) begin
      $display("FAIL req_fields: line=%0d x=%0d bank=%b required line=%0d x=%0d bank=%b",
               req_line, req_x, req_bank, el, ex, eb);
      miscompares++;
    end
    for (int i = 0; i < rdy_dly; i++) begin
      @(negedge pixel_clk);
      vectors++;
      if (req_valid !== 1'b1 || req_line !== el || req_x !== ex || req_bank !== eb) begin
        $display("FAIL req_hold: valid=%b line=%0d x=%0d bank=%b required 1 %0d %0d %b",
                 req_valid, req_line, req_x, req_bank, el, ex, eb);
        miscompares++;
      end
    end
    req_ready = 1'b1;
    @(negedge pixel_clk);
    req_ready = 1'b0;
    for (int i = 0; i < rsp_dly; i++) begin
      vectors++;
      if (req_valid !== 1'b0) begin
        $display("FAIL one_in_flight: req_valid=%b required 0", req_valid);
        miscompares++;
      end
      @(negedge pixel_clk);
    end
    rsp_done = 1'b1;
    if (dle) disp_line_end = 1'b1;
    @(negedge pixel_clk);
    rsp_done = 1'b0;
    disp_line_end = 1'b0;
    m_bursts++;
    if (dle) m_disp++;
    vectors++;
    if (req_valid !== 1'b0) begin
      $display("FAIL valid_after_rsp: req_valid=%b required 0", req_valid);
      miscompares++;
    end
    exp_rdy = (m_bursts / BPL) > m_disp;
    exp_ff  = (m_bursts / BPL) == VDISP;
    vectors++;
    if (disp_ready !== exp_rdy || disp_bank !== m_disp[0] || frame_fetched !== exp_ff) begin
      $display("FAIL disp_state: ready=%b bank=%b fetched=%b required %b %b %b",
               disp_ready, disp_bank, frame_fetched, exp_rdy, m_disp[0], exp_ff);
      miscompares++;
    end
  endtask

  // Run n bursts, releasing lines when both banks are full (and randomly if rnd).
  task automatic feed(input int n, input bit rnd);
    int f;
    bit dle;
    for (int k = 0; k < n; k++) begin
      f = m_bursts / BPL;
      if (f - m_disp == 2) begin
        repeat (2) @(negedge pixel_clk);
        vectors++;
        if (req_valid !== 1'b0) begin
          $display("FAIL stall_valid: req_valid=%b required 0", req_valid);
          miscompares++;
        end
        pulse_disp();
      end else if (rnd && f > m_disp && $urandom_range(0, 3) == 0) begin
        pulse_disp();
      end
      f = m_bursts / BPL;
      dle = rnd && (f > m_disp) && ($urandom_range(0, 5) == 0);
      if (rnd)
        do_burst(($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, $urandom_range(0, 3), dle);
      else
        do_burst(0, 0, 1'b0);
    end
  endtask

  task automatic test_reset();
    pixel_rst = 1'b1;
    repeat (3) @(negedge pixel_clk);
    vectors++;
    if (req_valid !== 1'b0 || req_line !== '0 || req_x !== '0 || req_bank !== 1'b0) begin
      $display("FAIL reset_req: valid=%b line=%0d x=%0d bank=%b required 0 0 0 0",
               req_valid, req_line, req_x, req_bank);
      miscompares++;
    end
    vectors++;
    if (disp_bank !== 1'b0 || disp_ready !== 1'b0 || underflow !== 1'b0 || frame_fetched !== 1'b0) begin
      $display("FAIL reset_disp: bank=%b ready=%b underflow=%b fetched=%b required 0 0 0 0",
               disp_bank, disp_ready, underflow, frame_fetched);
      miscompares++;
    end
    pixel_rst = 1'b0;
    repeat (5) @(negedge pixel_clk);
    vectors++;
    if (req_valid !== 1'b0) begin
      $display("FAIL idle_no_req: req_valid=%b required 0", req_valid);
      miscompares++;
    end
  endtask

  task automatic test_first_line();
    pulse_frame_start();
    m_bursts = 0;
    m_disp = 0;
    feed(BPL + 1, 1'b0);
  endtask

  task automatic test_bank_stall();
    feed(BPL - 1, 1'b0);
    repeat (4) @(negedge pixel_clk);
    vectors++;
    if (req_valid !== 1'b0 || req_line !== LW'(2) || req_bank !== 1'b0 || req_x !== '0) begin
      $display("FAIL bank_stall: valid=%b line=%0d bank=%b x=%0d required 0 2 0 0",
               req_valid, req_line, req_bank, req_x);
      miscompares++;
    end
    pulse_disp();
    vectors++;
    if (req_valid !== 1'b1 || disp_bank !== 1'b1 || disp_ready !== 1'b1) begin
      $display("FAIL bank_free: valid=%b disp_bank=%b disp_ready=%b required 1 1 1",
               req_valid, disp_bank, disp_ready);
      miscompares++;
    end
  endtask

  task automatic test_ready_hold();
    do_burst(20, 2, 1'b0);
  endtask

  task automatic test_random_frame();
    feed(400, 1'b1);
    feed(BPL * VDISP - m_bursts, 1'b0);
    vectors++;
    if (frame_fetched !== 1'b1) begin
      $display("FAIL frame_fetched: got %b required 1", frame_fetched);
      miscompares++;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge pixel_clk);
      vectors++;
      if (req_valid !== 1'b0) begin
        $display("FAIL done_no_req: req_valid=%b required 0", req_valid);
        miscompares++;
      end
    end
  endtask

  task automatic test_underflow();
    logic eb;
    while ((m_bursts / BPL) > m_disp) begin
      vectors++;
      if (disp_ready !== 1'b1) begin
        $display("FAIL drain_ready: disp_ready=%b required 1", disp_ready);
        miscompares++;
      end
      pulse_disp();
    end
    vectors++;
    if (disp_ready !== 1'b0 || underflow !== 1'b0) begin
      $display("FAIL drained: disp_ready=%b underflow=%b required 0 0", disp_ready, underflow);
      miscompares++;
    end
    eb = ~m_disp[0];
    pulse_disp();
    vectors++;
    if (underflow !== 1'b1 || disp_bank !== eb) begin
      $display("FAIL underflow_set: underflow=%b disp_bank=%b required 1 %b", underflow, disp_bank, eb);
      miscompares++;
    end
    repeat (5) @(negedge pixel_clk);
    vectors++;
    if (underflow !== 1'b1) begin
      $display("FAIL underflow_sticky: underflow=%b required 1", underflow);
      miscompares++;
    end
    pulse_frame_start();
    m_bursts = 0;
    m_disp = 0;
    vectors++;
    if (underflow !== 1'b0 || disp_bank !== 1'b0 || disp_ready !== 1'b0 || frame_fetched !== 1'b0) begin
      $display("FAIL frame_init: underflow=%b disp_bank=%b ready=%b fetched=%b required 0 0 0 0",
               underflow, disp_bank, disp_ready, frame_fetched);
      miscompares++;
    end
    do_burst(0, 1, 1'b0);
  endtask

  task automatic test_restart_wait();
    int t;
    feed(100 * BPL - m_bursts, 1'b0);
    if ((m_bursts / BPL) - m_disp == 2) pulse_disp();
    t = 0;
    while (req_valid !== 1'b1 && t < 64) begin
      @(negedge pixel_clk);
      t++;
    end
    vectors++;
    if (req_valid !== 1'b1 || req_line !== LW'(100) || req_x !== '0) begin
      $display("FAIL line100_req: valid=%b line=%0d x=%0d required 1 100 0", req_valid, req_line, req_x);
      miscompares++;
    end
    req_ready = 1'b1;
    @(negedge pixel_clk);
    req_ready = 1'b0;
    pulse_frame_start();
    for (int i = 0; i < 6; i++) begin
      if (i == 3) frame_start = 1'b1;
      @(negedge pixel_clk);
      frame_start = 1'b0;
      vectors++;
      if (req_valid !== 1'b0) begin
        $display("FAIL restart_hold: req_valid=%b required 0", req_valid);
        miscompares++;
      end
    end
    rsp_done = 1'b1;
    @(negedge pixel_clk);
    rsp_done = 1'b0;
    m_bursts = 0;
    m_disp = 0;
    vectors++;
    if (disp_bank !== 1'b0 || disp_ready !== 1'b0 || frame_fetched !== 1'b0 || req_valid !== 1'b0) begin
      $display("FAIL restart_init: disp_bank=%b ready=%b fetched=%b valid=%b required 0 0 0 0",
               disp_bank, disp_ready, frame_fetched, req_valid);
      miscompares++;
    end
    do_burst(0, 0, 1'b0);
  endtask

  task automatic test_reset_mid_wait();
    int t;
    feed(2 * BPL + 20, 1'b0);
    if ((m_bursts / BPL) - m_disp == 2) pulse_disp();
    t = 0;
    while (req_valid !== 1'b1 && t < 64) begin
      @(negedge pixel_clk);
      t++;
    end
    req_ready = 1'b1;
    @(negedge pixel_clk);
    req_ready = 1'b0;
    #2 pixel_rst = 1'b1;
    #1;
    vectors++;
    if (req_valid !== 1'b0 || req_line !== '0 || req_x !== '0 || req_bank !== 1'b0 ||
        disp_bank !== 1'b0 || disp_ready !== 1'b0 || underflow !== 1'b0 || frame_fetched !== 1'b0) begin
      $display("FAIL async_reset: valid=%b line=%0d x=%0d bank=%b dbank=%b ready=%b uf=%b ff=%b required all 0",
               req_valid, req_line, req_x, req_bank, disp_bank, disp_ready, underflow, frame_fetched);
      miscompares++;
    end
    @(negedge pixel_clk);
    pixel_rst = 1'b0;
    rsp_done = 1'b1;
    @(negedge pixel_clk);
    rsp_done = 1'b0;
    repeat (5) @(negedge pixel_clk);
    vectors++;
    if (req_valid !== 1'b0 || req_x !== '0) begin
      $display("FAIL post_reset_idle: valid=%b x=%0d required 0 0", req_valid, req_x);
      miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_bank_stall();
    test_ready_hold();
    test_random_frame();
    test_underflow();
    test_restart_wait();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
